arbiter_rr_lock: RTL
====================

ARBITER_RR_LOCK -- requirements
Module: arbiter_rr_lock

Interface
- REQ-001: Parameter NUM_PORTS, 5, number of input ports; legal range 2..16.
- REQ-002: Parameter LOCK_EN, 1, when 1 the grant is held across a packet until its tail flit; when 0 every flit re-arbitrates.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: Req  input  NUM_PORTS  per-port request; for NUM_PORTS=5, index 0=L, 1=N, 2=E, 3=W, 4=S.
- REQ-006: Tail  input  NUM_PORTS  per-port flag; 1 = the flit requesting is the packet's tail.
- REQ-007: DCTS  input  1  downstream clear-to-send.
- REQ-008: RTS  output  1  request-to-send toward downstream, registered.
- REQ-009: Grant  output  NUM_PORTS  one-hot flit grant, combinational, at most one bit set.
- REQ-010: Xbar_sel  output  NUM_PORTS  one-hot crossbar select of current owner, registered.
- REQ-011: Locked  output  1  1 while an owner holds the output mid-packet, registered.

Function
- REQ-012: FSM states IDLE, RTS_WAIT, GAP; registers: state, owner index, round-robin pointer ptr, lock flag.
- REQ-013: Winner = first index i with Req[i]=1 searching ptr, ptr+1, ... NUM_PORTS-1, 0, ... ptr-1 (wrap modulo NUM_PORTS).
- REQ-014: IDLE: if any Req bit set, owner <= winner, state <= RTS_WAIT; else stay IDLE.
- REQ-015: RTS=1 exactly while state=RTS_WAIT; Xbar_sel=onehot(owner) in RTS_WAIT and GAP, all-zero in IDLE.
- REQ-016: Grant = onehot(owner) when state=RTS_WAIT and DCTS=1 and Req[owner]=1, else all-zero.
- REQ-017: RTS_WAIT, DCTS=0, Req[owner]=1: hold state, owner, RTS, Xbar_sel unchanged (unbounded backpressure).
- REQ-018: RTS_WAIT with Req[owner]=0 (any DCTS): no grant, lock flag cleared, state <= IDLE, ptr unchanged.
- REQ-019: Grant cycle: state <= GAP; lock flag <= LOCK_EN and not Tail[owner] (sampled in grant cycle).
- REQ-020: Locked output = registered lock flag.
- REQ-021: GAP with lock flag=1: if Req[owner]=1 then state <= RTS_WAIT same owner, else stay GAP (owner waits for next flit; other ports blocked).
- REQ-022: GAP with lock flag=0: ptr <= (owner+1) mod NUM_PORTS; winner computed from that new pointer this cycle; if any Req, owner <= winner and state <= RTS_WAIT, else state <= IDLE.
- REQ-023: Throughput: at most one grant per two cycles; latency from Req sampled in IDLE to Grant = 1 cycle when DCTS=1.
- REQ-024: Tail ignored when LOCK_EN=0; behaviour then equals lock flag always 0.
- REQ-025: ptr updated only at packet release (REQ-022); lock flag and ptr never change in IDLE.

Reset
- REQ-026: rst=1 at a rising edge forces state=IDLE, owner=0, ptr=0, lock flag=0 regardless of any other input or current state.
- REQ-027: During and after reset cycle: RTS=0, Xbar_sel=0, Locked=0, Grant=0 (Grant forced 0 while rst=1).
- REQ-028: Reset mid-packet drops ownership; first arbitration after reset starts search at index 0.

Verification (NUM_PORTS=5, LOCK_EN=1 unless stated)
- REQ-029: rst=1 with Req=11111, DCTS=1 -> next cycle RTS=0, Grant=00000, Xbar_sel=00000, Locked=0.
- REQ-030: Req=00100, Tail=11111, DCTS=1 from IDLE -> cycle+1 RTS=1, Xbar_sel=00100, Grant=00100; cycle+2 GAP RTS=0; cycle+3 IDLE if Req=0.
- REQ-031: Req=11111 held, Tail=11111, DCTS=1 -> Grant sequence 00001, 00010, 00100, 01000, 10000, 00001 every second cycle.
- REQ-032: Req=00011, Tail[0]=0 for first two port-0 grants then 1 -> three consecutive Grant=00001 (Locked=1 between), then 00010.
- REQ-033: RTS_WAIT with DCTS=0 for 4 cycles -> RTS=1, Grant=0, Xbar_sel stable; DCTS=1 on 5th cycle -> Grant=onehot(owner).
- REQ-034: Locked owner port 3, rst=1 in GAP -> all outputs 0; then Req=11000 -> winner port 3 (search from 0), not port 4.

Source files
------------

// File: rtl/arbiter_rr_lock.sv
// Round-robin output-port arbiter with optional packet locking.
// One owner at a time gets the output. RTS is raised toward downstream.
// A flit is granted when downstream clear-to-send (DCTS) is high.
// With LOCK_EN set, the owner keeps the output until its tail flit goes through.
module arbiter_rr_lock #(
  parameter int NUM_PORTS = 5,
  parameter int LOCK_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] Req,
  input  logic [NUM_PORTS-1:0] Tail,
  input  logic                 DCTS,
  output logic                 RTS,
  output logic [NUM_PORTS-1:0] Grant,
  output logic [NUM_PORTS-1:0] Xbar_sel,
  output logic                 Locked
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RTS_WAIT = 2'd1,
    GAP      = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic             lock_flag;

  logic [IDX_W-1:0] win_ptr;
  logic [IDX_W-1:0] rel_ptr;
  logic [IDX_W-1:0] win_rel;
  logic             owner_req;
  logic             any_req;

  // Returns the first requesting index, searching upward from start and wrapping.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [IDX_W-1:0]     start);
    logic [IDX_W-1:0] result;
    logic             found;
    int               idx;
    result = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req[idx]) begin
        result = IDX_W'(idx);
        found  = 1'b1;
      end
    end
    return result;
  endfunction

  // Builds a one-hot port vector from an index.
  function automatic logic [NUM_PORTS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_PORTS-1:0] v;
    v = {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

  // A released packet hands priority to the port after the owner.
  assign rel_ptr   = (owner == IDX_W'(NUM_PORTS-1)) ? '0 : owner + IDX_W'(1);
  assign win_ptr   = pick(Req, ptr);
  assign win_rel   = pick(Req, rel_ptr);
  assign owner_req = Req[owner];
  assign any_req   = |Req;
  assign Locked    = lock_flag;

  // The flit grant is combinational so the owner can send in the same cycle DCTS rises.
  always_comb begin
    Grant = '0;
    if (!rst && (state == RTS_WAIT) && DCTS && owner_req) begin
      Grant = onehot(owner);
    end
  end

  // Arbitration FSM. RTS and Xbar_sel are registered together with the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      lock_flag <= 1'b0;
      RTS       <= 1'b0;
      Xbar_sel  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= win_ptr;
            state    <= RTS_WAIT;
            RTS      <= 1'b1;
            Xbar_sel <= onehot(win_ptr);
          end
        end

        RTS_WAIT: begin
          if (!owner_req) begin
            // The owner withdrew its request. Give up the output, but keep the pointer.
            lock_flag <= 1'b0;
            state     <= IDLE;
            RTS       <= 1'b0;
            Xbar_sel  <= '0;
          end else if (DCTS) begin
            state     <= GAP;
            RTS       <= 1'b0;
            lock_flag <= (LOCK_EN != 0) && !Tail[owner];
          end
        end

        GAP: begin
          if (lock_flag) begin
            // The packet is still open. Only the owner may continue, and others stay blocked.
            if (owner_req) begin
              state <= RTS_WAIT;
              RTS   <= 1'b1;
            end
          end else begin
            ptr <= rel_ptr;
            if (any_req) begin
              owner    <= win_rel;
              state    <= RTS_WAIT;
              RTS      <= 1'b1;
              Xbar_sel <= onehot(win_rel);
            end else begin
              state    <= IDLE;
              Xbar_sel <= '0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          owner     <= '0;
          lock_flag <= 1'b0;
          RTS       <= 1'b0;
          Xbar_sel  <= '0;
        end
      endcase
    end
  end

endmodule
